// File: rtl/unary_pkg.sv
// -----------------------------------------------------------------------------
// unary_pkg
// Shared types and constant helpers for the unary root unit.
//   state_t      : controller states (IDLE, COLLECT, SEARCH, EMIT)
//   count_width  : width of a counter able to hold 0..w
//   prod_width   : width of the power/target arithmetic for root order r
//   int_pow      : elaboration-time integer power, used for W^(R-1)
// -----------------------------------------------------------------------------
package unary_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEARCH  = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_INPUT_WIDTH = 8;
    localparam int unsigned DEFAULT_ROOT        = 2;

    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic int unsigned prod_width(input int unsigned w, input int unsigned r);
        return r * count_width(w) + 2;
    endfunction

    function automatic int unsigned int_pow(input int unsigned base, input int unsigned exp);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

endpackage

// File: rtl/unary_root_n_if.sv
// -----------------------------------------------------------------------------
// unary_root_n_if
// Stream interface of the unary root unit.
//   a      : input stream bit            (master -> slave)
//   ready  : input bit qualifier         (master -> slave)
//   busy   : unit is searching/emitting  (slave -> master)
//   valid  : y carries a result bit      (slave -> master)
//   y      : result thermometer bit      (slave -> master)
//   y_ones : result ones-count           (slave -> master)
// -----------------------------------------------------------------------------
interface unary_root_n_if
    import unary_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
    parameter int unsigned COUNT_WIDTH = count_width(INPUT_WIDTH)
) ();

    logic                   a;
    logic                   ready;
    logic                   busy;
    logic                   valid;
    logic                   y;
    logic [COUNT_WIDTH-1:0] y_ones;

    modport master (
        output a, ready,
        input  busy, valid, y, y_ones
    );

    modport slave (
        input  a, ready,
        output busy, valid, y, y_ones
    );

endinterface

// File: rtl/unary_int_pow.sv
// -----------------------------------------------------------------------------
// unary_int_pow
// Combinational integer power p = x^ROOT. OUT_WIDTH must be wide enough for
// the largest x presented; no saturation is applied.
//   x : IN_WIDTH-bit base
//   p : OUT_WIDTH-bit result
// -----------------------------------------------------------------------------
module unary_int_pow #(
    parameter int unsigned ROOT      = 2,
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 10
) (
    input  logic [IN_WIDTH-1:0]  x,
    output logic [OUT_WIDTH-1:0] p
);

    always_comb begin
        p = OUT_WIDTH'(1);
        for (int unsigned i = 0; i < ROOT; i++) begin
            p = p * OUT_WIDTH'(x);
        end
    end

endmodule

// File: rtl/unary_root_n.sv
// -----------------------------------------------------------------------------
// unary_root_n
// ROOT-th root of an INPUT_WIDTH-bit serial unary stream. Ones are counted
// while the stream arrives (gaps allowed), the root of a_ones*W^(R-1) is found
// by an MSB-first binary search, and the result is replayed as a W-bit
// thermometer stream.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : unary_root_n_if slave (a, ready in; busy, valid, y, y_ones out)
// Build option: define UNARY_ROOT_ROUND_EN for round-to-nearest results;
// otherwise the result is the floor of the root.
// -----------------------------------------------------------------------------
module unary_root_n
    import unary_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
    parameter int unsigned ROOT        = DEFAULT_ROOT,
    parameter int unsigned COUNT_WIDTH = count_width(INPUT_WIDTH),
    parameter int unsigned PROD_WIDTH  = prod_width(INPUT_WIDTH, ROOT)
) (
    input logic           clk,
    input logic           reset,
    unary_root_n_if.slave bus
);

    localparam int unsigned W_POW = int_pow(INPUT_WIDTH, ROOT - 1);

`ifdef UNARY_ROOT_ROUND_EN
    // (2k-1)^R is compared against T*2^R, so both sides need ROOT extra bits.
    localparam int unsigned BASE_WIDTH = COUNT_WIDTH + 1;
    localparam int unsigned CMP_WIDTH  = PROD_WIDTH + ROOT;
`else
    localparam int unsigned BASE_WIDTH = COUNT_WIDTH;
    localparam int unsigned CMP_WIDTH  = PROD_WIDTH;
`endif

    localparam logic [COUNT_WIDTH-1:0] W_CNT    = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] W_LAST   = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] MSB_MASK = COUNT_WIDTH'(1) << (COUNT_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] a_ones_q, a_ones_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] mask_q, mask_d;
    logic [COUNT_WIDTH-1:0] k_q, k_d;
    logic [COUNT_WIDTH-1:0] y_ones_q, y_ones_d;

    logic [COUNT_WIDTH-1:0] cand;
    logic [BASE_WIDTH-1:0]  base;
    logic [CMP_WIDTH-1:0]   target;
    logic [CMP_WIDTH-1:0]   power;
    logic                   accept;

    assign cand = k_q | mask_q;

`ifdef UNARY_ROOT_ROUND_EN
    assign base   = {cand, 1'b0} - BASE_WIDTH'(1);
    assign target = (CMP_WIDTH'(a_ones_q) * CMP_WIDTH'(W_POW)) << ROOT;
`else
    assign base   = cand;
    assign target = CMP_WIDTH'(a_ones_q) * CMP_WIDTH'(W_POW);
`endif

    unary_int_pow #(
        .ROOT      (ROOT),
        .IN_WIDTH  (BASE_WIDTH),
        .OUT_WIDTH (CMP_WIDTH)
    ) u_pow (
        .x (base),
        .p (power)
    );

    assign accept = (cand <= W_CNT) && (power <= target);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_ones_q <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            k_q      <= '0;
            y_ones_q <= '0;
        end else begin
            state_q  <= state_d;
            a_ones_q <= a_ones_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            k_q      <= k_d;
            y_ones_q <= y_ones_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_ones_d = a_ones_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        k_d      = k_q;
        y_ones_d = y_ones_q;

        case (state_q)
            IDLE: begin
                mask_d = MSB_MASK;
                k_d    = '0;
                if (bus.ready) begin
                    a_ones_d = COUNT_WIDTH'(bus.a);
                    cnt_d    = COUNT_WIDTH'(1);
                    state_d  = (INPUT_WIDTH == 1) ? SEARCH : COLLECT;
                end
            end
            COLLECT: begin
                mask_d = MSB_MASK;
                k_d    = '0;
                if (bus.ready) begin
                    a_ones_d = a_ones_q + COUNT_WIDTH'(bus.a);
                    cnt_d    = cnt_q + COUNT_WIDTH'(1);
                    if (cnt_q == W_LAST) begin
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                // One candidate bit per cycle while the mask is non-zero; the
                // cycle after the mask empties latches the result.
                if (mask_q != '0) begin
                    if (accept) begin
                        k_d = cand;
                    end
                    mask_d = mask_q >> 1;
                end else begin
                    y_ones_d = k_q;
                    cnt_d    = '0;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                cnt_d = cnt_q + COUNT_WIDTH'(1);
                if (cnt_q == W_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q == SEARCH) || (state_q == EMIT);
    assign bus.valid  = (state_q == EMIT);
    assign bus.y      = (state_q == EMIT) && (cnt_q < y_ones_q);
    assign bus.y_ones = y_ones_q;

endmodule

// File: tb/tb_unary_root_n.sv
// -----------------------------------------------------------------------------
// tb_unary_root_n
// Three W=8 units (ROOT 2, 3, 4) share one input stream. Each issued vector
// pushes the hand-computed result for every unit into that unit's queue; a
// monitor per unit pops on the first valid cycle and checks the thermometer
// bits, the burst length and y_ones.
// -----------------------------------------------------------------------------
module tb_unary_root_n;
    import unary_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

`ifdef UNARY_ROOT_ROUND_EN
    localparam int EXP2 [9] = '{0, 3, 4, 5, 6, 6, 7, 7, 8};
    localparam int EXP3 [9] = '{0, 4, 5, 6, 6, 7, 7, 8, 8};
    localparam int EXP4 [9] = '{0, 5, 6, 6, 7, 7, 7, 8, 8};
`else
    localparam int EXP2 [9] = '{0, 2, 4, 4, 5, 6, 6, 7, 8};
    localparam int EXP3 [9] = '{0, 4, 5, 5, 6, 6, 7, 7, 8};
    localparam int EXP4 [9] = '{0, 4, 5, 6, 6, 7, 7, 7, 8};
`endif

    logic clk = 1'b0;
    logic reset;
    logic a_drv;
    logic ready_drv;

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int q2 [$];
    int q3 [$];
    int q4 [$];

    unary_root_n_if #(.INPUT_WIDTH(W)) bus2 ();
    unary_root_n_if #(.INPUT_WIDTH(W)) bus3 ();
    unary_root_n_if #(.INPUT_WIDTH(W)) bus4 ();

    assign bus2.a = a_drv;  assign bus2.ready = ready_drv;
    assign bus3.a = a_drv;  assign bus3.ready = ready_drv;
    assign bus4.a = a_drv;  assign bus4.ready = ready_drv;

    unary_root_n #(.INPUT_WIDTH(W), .ROOT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    unary_root_n #(.INPUT_WIDTH(W), .ROOT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    unary_root_n #(.INPUT_WIDTH(W), .ROOT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- scoreboard monitors ----------------
    logic in_burst [3];
    int   idx      [3];
    int   cur      [3];
    int   ones     [3];

    task automatic mon(input int id, input logic v, input logic yb, input int yo);
        int sz;
        if (reset) begin
            in_burst[id] = 1'b0;
            return;
        end
        if (v) begin
            if (!in_burst[id]) begin
                in_burst[id] = 1'b1;
                idx[id]      = 0;
                ones[id]     = 0;
                case (id)
                    0: sz = q2.size();
                    1: sz = q3.size();
                    default: sz = q4.size();
                endcase
                check($sformatf("r%0d_pending", id + 2), int'(sz > 0), 1);
                cur[id] = -1;
                if (sz > 0) begin
                    case (id)
                        0: cur[id] = q2.pop_front();
                        1: cur[id] = q3.pop_front();
                        default: cur[id] = q4.pop_front();
                    endcase
                end
            end
            check($sformatf("r%0d_ybit%0d", id + 2, idx[id]), int'(yb), int'(idx[id] < cur[id]));
            ones[id] += int'(yb);
            idx[id]++;
        end else begin
            check($sformatf("r%0d_y_idle", id + 2), int'(yb), 0);
            if (in_burst[id]) begin
                in_burst[id] = 1'b0;
                check($sformatf("r%0d_valid_len", id + 2), idx[id], W);
                check($sformatf("r%0d_y_ones", id + 2), yo, cur[id]);
                check($sformatf("r%0d_stream_ones", id + 2), ones[id], cur[id]);
            end
        end
    endtask

    always @(posedge clk) begin #1; mon(0, bus2.valid, bus2.y, int'(bus2.y_ones)); end
    always @(posedge clk) begin #1; mon(1, bus3.valid, bus3.y, int'(bus3.y_ones)); end
    always @(posedge clk) begin #1; mon(2, bus4.valid, bus4.y, int'(bus4.y_ones)); end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int n);
        q2.push_back(EXP2[n]);
        q3.push_back(EXP3[n]);
        q4.push_back(EXP4[n]);
    endtask

    task automatic drive_bit(input logic b);
        ready_drv = 1'b1;
        a_drv     = b;
        @(negedge clk);
        ready_drv = 1'b0;
        a_drv     = 1'b0;
    endtask

    task automatic send_vec(input int n, input int maxgap);
        for (int i = 0; i < W; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                a_drv = 1'($urandom_range(1, 0));
                @(negedge clk);
            end
            drive_bit(i < n);
        end
        push_exp(n);
    endtask

    task automatic pulse_busy();
        repeat (3) begin
            ready_drv = 1'b1;
            a_drv     = 1'b1;
            @(negedge clk);
        end
        ready_drv = 1'b0;
        a_drv     = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bus2.busy || bus3.busy || bus4.busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_within_bound", int'(t < 200), 1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},   int'(bus2.busy | bus3.busy | bus4.busy), 0);
        check({tag, "_valid"},  int'(bus2.valid | bus3.valid | bus4.valid), 0);
        check({tag, "_y"},      int'(bus2.y | bus3.y | bus4.y), 0);
        check({tag, "_y_ones"}, int'(bus2.y_ones | bus3.y_ones | bus4.y_ones), 0);
    endtask

    initial begin
        int e;
        reset     = 1'b1;
        a_drv     = 1'b0;
        ready_drv = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clk);

        // Two ones with R=2: y_ones 4; valid rises CW+1 edges after last bit.
        send_vec(2, 0);
        e = 0;
        while (!bus2.valid && e < 50) begin
            @(negedge clk);
            e++;
        end
        check("latency_edges", e, CW + 1);
        wait_idle();

        send_vec(3, 0); wait_idle();
        send_vec(1, 0); wait_idle();
        send_vec(8, 0); wait_idle();
        send_vec(0, 0); wait_idle();

        for (int n = 0; n <= W; n++) begin
            send_vec(n, 0);
            wait_idle();
        end

        // Bursty input with ready pulses while busy.
        send_vec(5, 5); pulse_busy(); wait_idle();
        send_vec(2, 5); pulse_busy(); wait_idle();
        send_vec(7, 3); pulse_busy(); wait_idle();

        // Reset mid-COLLECT, coinciding with an accepted-looking ready.
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset     = 1'b1;
        ready_drv = 1'b1;
        a_drv     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        ready_drv = 1'b0;
        a_drv     = 1'b0;
        check_cleared("rst_collect");
        send_vec(0, 0); wait_idle();

        // Reset mid-EMIT.
        send_vec(8, 0);
        e = 0;
        while (!bus2.valid && e < 50) begin
            @(negedge clk);
            e++;
        end
        check("emit_reached", int'(bus2.valid), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("rst_emit");
        send_vec(8, 0); wait_idle();

        repeat (5) @(negedge clk);
        check("q2_drained", q2.size(), 0);
        check("q3_drained", q3.size(), 0);
        check("q4_drained", q4.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
